// File: rtl/tl_ul_pkg.sv
// ----------------------------------------------------------------------------
// tl_ul_pkg
//   Shared TileLink-UL definitions for the port buffer slice: opcode
//   encodings and the packed A/D channel beat layouts.
//   tl_a_t (82 bits): {opcode, param, size, source, address, mask, data, corrupt}
//   tl_d_t (47 bits): {opcode, param, size, source, sink, denied, data, corrupt}
// ----------------------------------------------------------------------------
package tl_ul_pkg;

   typedef enum logic [2:0] {
      A_PUT_FULL    = 3'd0,
      A_PUT_PARTIAL = 3'd1,
      A_ARITHMETIC  = 3'd2,
      A_LOGICAL     = 3'd3,
      A_GET         = 3'd4,
      A_INTENT      = 3'd5
   } tl_a_op_e;

   typedef enum logic [2:0] {
      D_ACCESS_ACK      = 3'd0,
      D_ACCESS_ACK_DATA = 3'd1,
      D_HINT_ACK        = 3'd2
   } tl_d_op_e;

   typedef struct packed {
      tl_a_op_e    opcode;
      logic [2:0]  param;
      logic [3:0]  size;
      logic [2:0]  source;
      logic [31:0] address;
      logic [3:0]  mask;
      logic [31:0] data;
      logic        corrupt;
   } tl_a_t;

   typedef struct packed {
      tl_d_op_e    opcode;
      logic [1:0]  param;
      logic [3:0]  size;
      logic [2:0]  source;
      logic        sink;
      logic        denied;
      logic [31:0] data;
      logic        corrupt;
   } tl_d_t;

   localparam int unsigned TL_A_W = $bits(tl_a_t);
   localparam int unsigned TL_D_W = $bits(tl_d_t);

endpackage

// File: rtl/tl_ul_buffer_fifo.sv
// ----------------------------------------------------------------------------
// tl_ul_buffer_fifo
//   In-order FIFO of DEPTH entries (power of two, >= 2) used for one
//   TileLink channel. A written entry becomes visible on the read side one
//   cycle later; there is no empty bypass. wr_ready is derived only from the
//   pointer registers.
//   Ports: clock, reset_n (async, active-low)
//          wr_valid/wr_ready/wr_data : enqueue side
//          rd_valid/rd_ready/rd_data : dequeue side (rd_data = head entry)
// ----------------------------------------------------------------------------
module tl_ul_buffer_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic full, empty, wr_fire, rd_fire;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_ready = !full;
   assign rd_valid = !empty;
   assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign wr_fire  = wr_valid && wr_ready;
   assign rd_fire  = rd_valid && rd_ready;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: payload storage has no reset; clearing the pointers already makes every entry invalid.
   always_ff @(posedge clock) begin
      if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/tl_ul_port_buffer.sv
// ----------------------------------------------------------------------------
// tl_ul_port_buffer
//   One-stage-latency buffer for a TileLink-UL port: an A-channel FIFO toward
//   the monitored link, a D-channel FIFO back upstream, and an outstanding
//   request counter with an unexpected-response error pulse.
//   Ports: clock, reset_n (async, active-low)
//          in_a_*  / out_a_* : A channel upstream / downstream
//          in_d_*  / out_d_* : D channel downstream / upstream
//          inflight          : A beats sent without a returned D beat
//          err_d_unexpected  : 1-cycle pulse after a D beat seen with inflight==0
//   Build option: define TLUL_BUF_INFLIGHT_LIMIT_EN to stall out_a while
//   inflight==MAX_INFLIGHT; otherwise inflight saturates at 7.
// ----------------------------------------------------------------------------
module tl_ul_port_buffer
   import tl_ul_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       in_a_valid,
   output logic       in_a_ready,
   input  tl_a_t      in_a_bits,
   output logic       out_a_valid,
   input  logic       out_a_ready,
   output tl_a_t      out_a_bits,
   input  logic       in_d_valid,
   output logic       in_d_ready,
   input  tl_d_t      in_d_bits,
   output logic       out_d_valid,
   input  logic       out_d_ready,
   output tl_d_t      out_d_bits,
   output logic [2:0] inflight,
   output logic       err_d_unexpected
);

   localparam logic [2:0] INFLIGHT_SAT = 3'd7;

   logic              a_nonempty, a_fire, d_fire, a_blocked;
   logic [TL_A_W-1:0] a_head;
   logic [TL_D_W-1:0] d_head;
   logic [2:0]        inflight_q, inflight_d;
   logic              err_q, err_d;

   tl_ul_buffer_fifo #(.WIDTH(TL_A_W), .DEPTH(DEPTH)) u_fifo_a (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_valid (in_a_valid),
      .wr_ready (in_a_ready),
      .wr_data  (in_a_bits),
      .rd_valid (a_nonempty),
      .rd_ready (a_fire),
      .rd_data  (a_head)
   );

   tl_ul_buffer_fifo #(.WIDTH(TL_D_W), .DEPTH(DEPTH)) u_fifo_d (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_valid (in_d_valid),
      .wr_ready (in_d_ready),
      .wr_data  (in_d_bits),
      .rd_valid (out_d_valid),
      .rd_ready (out_d_ready),
      .rd_data  (d_head)
   );

   assign d_fire = in_d_valid && in_d_ready;

`ifdef TLUL_BUF_INFLIGHT_LIMIT_EN
   // A returning D beat on this edge frees a slot, so the ceiling only
   // blocks when no response is landing at the same time.
   assign a_blocked = (inflight_q == 3'(MAX_INFLIGHT)) && !d_fire;
`else
   logic unused_max_inflight;
   assign unused_max_inflight = ^3'(MAX_INFLIGHT);
   assign a_blocked           = 1'b0;
`endif

   assign out_a_valid = a_nonempty && !a_blocked;
   assign a_fire      = out_a_valid && out_a_ready;
   assign out_a_bits  = tl_a_t'(a_head);
   assign out_d_bits  = tl_d_t'(d_head);

   always_comb begin
      inflight_d = inflight_q;
      err_d      = 1'b0;
      unique case ({a_fire, d_fire})
         2'b10: begin
            if (inflight_q != INFLIGHT_SAT) inflight_d = inflight_q + 3'd1;
         end
         2'b01: begin
            // A response with nothing outstanding is flagged, not counted.
            if (inflight_q == 3'd0) err_d = 1'b1;
            else                    inflight_d = inflight_q - 3'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inflight_q <= 3'd0;
         err_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign inflight         = inflight_q;
   assign err_d_unexpected = err_q;

endmodule

// File: tb/tb_tl_ul_port_buffer.sv
// ----------------------------------------------------------------------------
// tb_tl_ul_port_buffer
//   Directed bench for tl_ul_port_buffer at DEPTH=2, MAX_INFLIGHT=4.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_tl_ul_port_buffer;
   import tl_ul_pkg::*;

`ifdef TLUL_BUF_INFLIGHT_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n;
   logic       in_a_valid, in_a_ready, out_a_valid, out_a_ready;
   tl_a_t      in_a_bits, out_a_bits;
   logic       in_d_valid, in_d_ready, out_d_valid, out_d_ready;
   tl_d_t      in_d_bits, out_d_bits;
   logic [2:0] inflight;
   logic       err_d_unexpected;

   int checks = 0;
   int passed = 0;

   tl_a_t a_get, b [3], c [4], e [5], f [2];
   tl_d_t d_ack, d_unx, g [2];

   tl_ul_port_buffer #(.DEPTH(2), .MAX_INFLIGHT(4)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .in_a_valid       (in_a_valid),
      .in_a_ready       (in_a_ready),
      .in_a_bits        (in_a_bits),
      .out_a_valid      (out_a_valid),
      .out_a_ready      (out_a_ready),
      .out_a_bits       (out_a_bits),
      .in_d_valid       (in_d_valid),
      .in_d_ready       (in_d_ready),
      .in_d_bits        (in_d_bits),
      .out_d_valid      (out_d_valid),
      .out_d_ready      (out_d_ready),
      .out_d_bits       (out_d_bits),
      .inflight         (inflight),
      .err_d_unexpected (err_d_unexpected)
   );

   always #5 clock = ~clock;

   function automatic tl_a_t mk_a(input tl_a_op_e op, input logic [2:0] src,
                                  input logic [31:0] addr, input logic [31:0] data);
      tl_a_t a;
      a.opcode  = op;
      a.param   = 3'd0;
      a.size    = 4'd2;
      a.source  = src;
      a.address = addr;
      a.mask    = 4'hf;
      a.data    = data;
      a.corrupt = 1'b0;
      return a;
   endfunction

   function automatic tl_d_t mk_d(input tl_d_op_e op, input logic [2:0] src,
                                  input logic [31:0] data);
      tl_d_t d;
      d.opcode  = op;
      d.param   = 2'd0;
      d.size    = 4'd2;
      d.source  = src;
      d.sink    = 1'b0;
      d.denied  = 1'b0;
      d.data    = data;
      d.corrupt = 1'b0;
      return d;
   endfunction

   task automatic check(input string tag, input logic [81:0] obs, input logic [81:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Return n D beats back-to-back, then let the last one leave out_d.
   task automatic drain_d(input int n);
      in_d_bits  = mk_d(D_ACCESS_ACK, 3'd1, 32'h0);
      in_d_valid = 1'b1;
      repeat (n) step();
      in_d_valid = 1'b0;
      step();
   endtask

   initial begin
      a_get = mk_a(A_GET, 3'd3, 32'h8000_0000, 32'h0);
      d_ack = mk_d(D_ACCESS_ACK_DATA, 3'd3, 32'hdead_beef);
      d_unx = mk_d(D_ACCESS_ACK, 3'd5, 32'h0);
      for (int i = 0; i < 3; i++) b[i] = mk_a(A_PUT_FULL, 3'(i), 32'h1000 + 32'(4*i), 32'hA0 + 32'(i));
      for (int i = 0; i < 4; i++) c[i] = mk_a(A_GET, 3'(i), 32'h2000 + 32'(4*i), 32'h0);
      for (int i = 0; i < 5; i++) e[i] = mk_a(A_PUT_PARTIAL, 3'(i), 32'h3000 + 32'(4*i), 32'hE0 + 32'(i));
      for (int i = 0; i < 2; i++) f[i] = mk_a(A_GET, 3'(i), 32'h4000 + 32'(4*i), 32'h0);
      for (int i = 0; i < 2; i++) g[i] = mk_d(D_ACCESS_ACK_DATA, 3'(i), 32'h5000 + 32'(i));

      // Reset state
      reset_n = 1'b0;
      in_a_valid = 1'b0; in_a_bits = '0; out_a_ready = 1'b0;
      in_d_valid = 1'b0; in_d_bits = '0; out_d_ready = 1'b0;
      step(); step();
      check("rst_out_a_valid", out_a_valid, 0);
      check("rst_out_d_valid", out_d_valid, 0);
      check("rst_inflight", inflight, 0);
      check("rst_err", err_d_unexpected, 0);
      reset_n = 1'b1;
      step();
      check("rel_in_a_ready", in_a_ready, 1);
      check("rel_in_d_ready", in_d_ready, 1);

      // Single Get beat: one cycle latency, no bypass
      out_a_ready = 1'b1; out_d_ready = 1'b1;
      in_a_bits = a_get; in_a_valid = 1'b1;
      #1;
      check("no_bypass", out_a_valid, 0);
      step();
      in_a_valid = 1'b0;
      check("get_valid", out_a_valid, 1);
      check("get_bits", out_a_bits, a_get);
      check("get_inflight_pre", inflight, 0);
      step();
      check("get_drained", out_a_valid, 0);
      check("get_inflight", inflight, 1);

      // Matching response decrements inflight and is forwarded
      in_d_bits = d_ack; in_d_valid = 1'b1;
      step();
      in_d_valid = 1'b0;
      check("ack_inflight", inflight, 0);
      check("ack_out_valid", out_d_valid, 1);
      check("ack_out_bits", out_d_bits, d_ack);
      check("ack_no_err", err_d_unexpected, 0);
      step();
      check("ack_drained", out_d_valid, 0);

      // Unexpected response: one-cycle error pulse, still forwarded
      in_d_bits = d_unx; in_d_valid = 1'b1;
      step();
      in_d_valid = 1'b0;
      check("unx_err_hi", err_d_unexpected, 1);
      check("unx_inflight", inflight, 0);
      check("unx_out_valid", out_d_valid, 1);
      check("unx_out_bits", out_d_bits, d_unx);
      step();
      check("unx_err_lo", err_d_unexpected, 0);
      check("unx_drained", out_d_valid, 0);

      // Backpressure: third beat stalls, then in-order release
      out_a_ready = 1'b0;
      in_a_valid = 1'b1; in_a_bits = b[0];
      step();
      check("bp_ready_1", in_a_ready, 1);
      check("bp_head_b0", out_a_bits, b[0]);
      in_a_bits = b[1];
      step();
      check("bp_full", in_a_ready, 0);
      in_a_bits = b[2];
      step();
      check("bp_stall", in_a_ready, 0);
      check("bp_hold_valid", out_a_valid, 1);
      check("bp_hold_bits", out_a_bits, b[0]);
      out_a_ready = 1'b1;
      step();
      check("rel_head_b1", out_a_bits, b[1]);
      check("rel_ready", in_a_ready, 1);
      step();
      in_a_valid = 1'b0;
      check("rel_head_b2", out_a_bits, b[2]);
      check("rel_valid_b2", out_a_valid, 1);
      step();
      check("rel_empty", out_a_valid, 0);
      check("rel_inflight", inflight, 3);
      drain_d(3);
      check("rel_drain_inflight", inflight, 0);
      check("rel_drain_d", out_d_valid, 0);

      // Full FIFO with both sides active: one beat leaves every cycle
      out_a_ready = 1'b0;
      in_a_valid = 1'b1; in_a_bits = c[0];
      step();
      in_a_bits = c[1];
      step();
      check("thr_full", in_a_ready, 0);
      out_a_ready = 1'b1; in_a_bits = c[2];
      step();
      check("thr_v1", out_a_valid, 1);
      check("thr_b1", out_a_bits, c[1]);
      step();
      in_a_bits = c[3];
      check("thr_v2", out_a_valid, 1);
      check("thr_b2", out_a_bits, c[2]);
      step();
      in_a_valid = 1'b0;
      check("thr_v3", out_a_valid, 1);
      check("thr_b3", out_a_bits, c[3]);
      step();
      check("thr_empty", out_a_valid, 0);
      check("thr_inflight", inflight, 4);
      drain_d(4);
      check("thr_drain_inflight", inflight, 0);

      // Outstanding ceiling: five beats, no responses
      in_a_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_a_bits = e[i];
         step();
      end
      in_a_valid = 1'b0;
      check("lim_inflight_4", inflight, 4);
      check("lim_valid_at_4", out_a_valid, LIM ? 0 : 1);
      step();
      check("lim_hold_inflight", inflight, LIM ? 4 : 5);
      check("lim_hold_valid", out_a_valid, 0);
      in_d_bits = d_ack; in_d_valid = 1'b1;
      #1;
      check("lim_d_unblocks", out_a_valid, LIM ? 1 : 0);
      step();
      in_d_valid = 1'b0;
      check("lim_after_d_inflight", inflight, 4);
      check("lim_after_d_valid", out_a_valid, 0);
      drain_d(4);
      check("lim_drain_inflight", inflight, 0);

      // Reset with both channels holding two beats
      out_a_ready = 1'b0; out_d_ready = 1'b0;
      in_a_valid = 1'b1; in_d_valid = 1'b1;
      in_a_bits = f[0]; in_d_bits = g[0];
      step();
      in_a_bits = f[1]; in_d_bits = g[1];
      step();
      in_a_valid = 1'b0; in_d_valid = 1'b0;
      check("mid_a_valid", out_a_valid, 1);
      check("mid_d_valid", out_d_valid, 1);
      check("mid_a_full", in_a_ready, 0);
      check("mid_d_full", in_d_ready, 0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_a_valid", out_a_valid, 0);
      check("mid_rst_d_valid", out_d_valid, 0);
      check("mid_rst_inflight", inflight, 0);
      #3;
      reset_n = 1'b1;
      out_a_ready = 1'b1; out_d_ready = 1'b1;
      step();
      check("post_a_valid", out_a_valid, 0);
      check("post_d_valid", out_d_valid, 0);
      check("post_a_ready", in_a_ready, 1);
      check("post_d_ready", in_d_ready, 1);
      step();
      check("post2_a_valid", out_a_valid, 0);
      check("post2_d_valid", out_d_valid, 0);
      check("post2_inflight", inflight, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
